// File: rtl/clk_step_ctrl_if.sv
// Host command channel for the clock-step controller: valid/ready handshake
// carrying an opcode and a step-count argument.
interface clk_step_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_arg;

    modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/clk_step_ctrl.sv
// Clock-step controller: drives a registered clock-enable for HALT / free RUN /
// N-cycle STEP operation, with backpressure stalling and cycle/stall counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// HALT  | gate_en held low, waiting for a host command
// RUN   | gate_en high every cycle not blocked by bp_full / halt_req
// STEP  | gate_en high for step_left more unblocked cycles, then HALT
module clk_step_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    clk_step_ctrl_if.slave      cmd,
    input  logic                halt_req,
    input  logic                bp_full,
    output logic                gate_en,
    output logic [1:0]          state,
    output logic [CNT_W-1:0]    step_left,
    output logic                done_pulse,
    output logic [63:0]         cycle_cnt,
    output logic [31:0]         stall_cnt
);
    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_STEP  = 2'b10;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic             gate_en_q, gate_en_d;
    logic [CNT_W-1:0] step_left_q, step_left_d;
    logic             done_q, done_d;
    logic [63:0]      cycle_cnt_q, cycle_cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             rdy_q;
    logic             bp_q;

    logic accept;
    logic is_step;
    logic is_clr;
    logic step_zero;
    logic completing;

    assign accept     = cmd.cmd_valid && rdy_q;
    assign is_step    = accept && (cmd.cmd_op == OP_STEP) && !halt_req;
    assign is_clr     = accept && (cmd.cmd_op == OP_CLR);
    assign step_zero  = (cmd.cmd_arg == '0);
    assign completing = (state_q == S_STEP) && gate_en_q && (step_left_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_HALT;
            gate_en_q   <= 1'b0;
            step_left_q <= '0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            rdy_q       <= 1'b0;
            bp_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_en_q   <= gate_en_d;
            step_left_q <= step_left_d;
            done_q      <= done_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            rdy_q       <= 1'b1;
            bp_q        <= bp_full;
        end
    end

    // Completion first, then an accepted command, then halt_req overrides all.
    always_comb begin
        state_d = state_q;
        if (completing) begin
            state_d = S_HALT;
        end
        if (accept) begin
            case (cmd.cmd_op)
                OP_HALT: state_d = S_HALT;
                OP_RUN:  state_d = S_RUN;
                OP_STEP: state_d = step_zero ? S_HALT : S_STEP;
                default: state_d = state_d;
            endcase
        end
        if (halt_req) begin
            state_d = S_HALT;
        end
    end

    always_comb begin
        gate_en_d = ((state_d == S_RUN) || (state_d == S_STEP)) && !bp_full && !halt_req;
        done_d    = completing || (is_step && step_zero);

        step_left_d = step_left_q;
        if ((state_q == S_STEP) && gate_en_q && (step_left_q != '0)) begin
            step_left_d = step_left_q - CNT_W'(1);
        end
        if (is_step && !step_zero) begin
            step_left_d = cmd.cmd_arg;
        end
        if (state_d != S_STEP) begin
            step_left_d = '0;
        end

        cycle_cnt_d = cycle_cnt_q + {63'd0, gate_en_q};

        // A stall cycle is one whose enable was withheld by last cycle's bp_full.
        stall_cnt_d = stall_cnt_q;
        if (((state_q == S_RUN) || (state_q == S_STEP)) && !gate_en_q && bp_q
            && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end

        if (is_clr) begin
            cycle_cnt_d = '0;
            stall_cnt_d = '0;
        end
    end

    assign cmd.cmd_ready = rdy_q;
    assign gate_en       = gate_en_q;
    assign state         = state_q;
    assign step_left     = step_left_q;
    assign done_pulse    = done_q;
    assign cycle_cnt     = cycle_cnt_q;
    assign stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl: expected post-edge values are queued as
// stimulus is driven and compared one step after each rising edge.
module tb_clk_step_ctrl;
    localparam int CNT_W = 32;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic             clk = 1'b0;
    logic             rstn;
    logic             halt_req;
    logic             bp_full;
    logic             gate_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] step_left;
    logic             done_pulse;
    logic [63:0]      cycle_cnt;
    logic [31:0]      stall_cnt;

    clk_step_ctrl_if #(.CNT_W(CNT_W)) cmd_if ();

    clk_step_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd        (cmd_if),
        .halt_req   (halt_req),
        .bp_full    (bp_full),
        .gate_en    (gate_en),
        .state      (state),
        .step_left  (step_left),
        .done_pulse (done_pulse),
        .cycle_cnt  (cycle_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {SEL_STATE, SEL_GATE, SEL_DONE, SEL_LEFT, SEL_CYC, SEL_STALL, SEL_RDY} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [63:0] obs(sel_t s);
        case (s)
            SEL_STATE: return {62'd0, state};
            SEL_GATE:  return {63'd0, gate_en};
            SEL_DONE:  return {63'd0, done_pulse};
            SEL_LEFT:  return {32'd0, step_left};
            SEL_CYC:   return cycle_cnt;
            SEL_STALL: return {32'd0, stall_cnt};
            default:   return {63'd0, cmd_if.cmd_ready};
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_t s, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_ctl(input string tag, input logic [1:0] st, input logic ge,
                              input logic dp, input logic [63:0] sl);
        expect_val({tag, ".state"}, SEL_STATE, {62'd0, st});
        expect_val({tag, ".gate"},  SEL_GATE,  {63'd0, ge});
        expect_val({tag, ".done"},  SEL_DONE,  {63'd0, dp});
        expect_val({tag, ".left"},  SEL_LEFT,  sl);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [63:0] o;
            e = sb.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] arg);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
    endtask

    task automatic idle();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_HALT;
        cmd_if.cmd_arg   = '0;
    endtask

    initial begin
        rstn     = 1'b0;
        halt_req = 1'b0;
        bp_full  = 1'b0;
        idle();

        // reset state
        tick();
        expect_ctl("rst", 2'b00, 1'b0, 1'b0, 0);
        expect_val("rst.cyc", SEL_CYC, 0);
        expect_val("rst.stall", SEL_STALL, 0);
        expect_val("rst.rdy", SEL_RDY, 0);
        tick();

        // first cycle after release: not ready, command is not taken
        rstn = 1'b1;
        send(OP_RUN, 0);
        expect_val("rel.rdy0", SEL_RDY, 0);
        #1;
        drain();
        expect_val("rel.rdy1", SEL_RDY, 1);
        expect_val("rel.state", SEL_STATE, 0);
        tick();

        // STEP N=5: five enabled cycles, done on the sixth
        send(OP_STEP, 5);
        expect_ctl("s5.c1", 2'b10, 1'b1, 1'b0, 5);
        tick();
        idle();
        for (int k = 4; k >= 1; k--) begin
            expect_ctl($sformatf("s5.left%0d", k), 2'b10, 1'b1, 1'b0, k);
            tick();
        end
        expect_ctl("s5.done", 2'b00, 1'b0, 1'b1, 0);
        expect_val("s5.cyc", SEL_CYC, 5);
        tick();
        expect_ctl("s5.after", 2'b00, 1'b0, 1'b0, 0);
        tick();

        // CLR in HALT, then STEP N=4 with a 3-cycle backpressure stall
        send(OP_CLR, 0);
        expect_val("clr0.cyc", SEL_CYC, 0);
        expect_val("clr0.stall", SEL_STALL, 0);
        expect_val("clr0.state", SEL_STATE, 0);
        tick();
        send(OP_STEP, 4);
        expect_ctl("s4.c1", 2'b10, 1'b1, 1'b0, 4);
        tick();
        idle();
        expect_ctl("s4.c2", 2'b10, 1'b1, 1'b0, 3);
        tick();
        bp_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_ctl($sformatf("s4.stall%0d", k), 2'b10, 1'b0, 1'b0, 2);
            tick();
        end
        bp_full = 1'b0;
        expect_ctl("s4.resume", 2'b10, 1'b1, 1'b0, 2);
        tick();
        expect_ctl("s4.last", 2'b10, 1'b1, 1'b0, 1);
        tick();
        expect_ctl("s4.done", 2'b00, 1'b0, 1'b1, 0);
        expect_val("s4.cyc", SEL_CYC, 4);
        expect_val("s4.stall", SEL_STALL, 3);
        tick();

        // RUN, then halt_req together with a RUN command at cycle 10
        send(OP_RUN, 0);
        expect_ctl("run.c1", 2'b01, 1'b1, 1'b0, 0);
        tick();
        idle();
        for (int k = 2; k <= 10; k++) begin
            expect_val($sformatf("run.gate%0d", k), SEL_GATE, 1);
            tick();
        end
        halt_req = 1'b1;
        send(OP_RUN, 0);
        expect_ctl("halt.c11", 2'b00, 1'b0, 1'b0, 0);
        expect_val("halt.cyc", SEL_CYC, 14);
        tick();
        halt_req = 1'b0;
        idle();
        expect_ctl("halt.c12", 2'b00, 1'b0, 1'b0, 0);
        tick();

        // STEP N=0 is a no-op with a done pulse
        send(OP_STEP, 0);
        expect_ctl("s0.done", 2'b00, 1'b0, 1'b1, 0);
        tick();
        idle();
        expect_ctl("s0.after", 2'b00, 1'b0, 1'b0, 0);
        tick();

        // CLR during RUN: counters zero, then count again, state stays RUN
        send(OP_RUN, 0);
        expect_ctl("crun.c1", 2'b01, 1'b1, 1'b0, 0);
        tick();
        send(OP_CLR, 0);
        expect_val("crun.cyc0", SEL_CYC, 0);
        expect_val("crun.stall0", SEL_STALL, 0);
        expect_val("crun.state", SEL_STATE, 1);
        tick();
        idle();
        expect_val("crun.cyc1", SEL_CYC, 1);
        tick();
        expect_val("crun.cyc2", SEL_CYC, 2);
        expect_val("crun.state2", SEL_STATE, 1);
        tick();

        // STEP reload mid-step, then RUN in the completing cycle
        send(OP_STEP, 3);
        expect_ctl("rl.c1", 2'b10, 1'b1, 1'b0, 3);
        tick();
        idle();
        expect_ctl("rl.c2", 2'b10, 1'b1, 1'b0, 2);
        tick();
        send(OP_STEP, 2);
        expect_ctl("rl.reload", 2'b10, 1'b1, 1'b0, 2);
        tick();
        idle();
        expect_ctl("rl.last", 2'b10, 1'b1, 1'b0, 1);
        tick();
        send(OP_RUN, 0);
        expect_ctl("rl.done_run", 2'b01, 1'b1, 1'b1, 0);
        tick();
        send(OP_HALT, 0);
        expect_ctl("rl.halt", 2'b00, 1'b0, 1'b0, 0);
        tick();

        // reset in the middle of a STEP with step_left=3
        send(OP_STEP, 5);
        expect_val("mr.l5", SEL_LEFT, 5);
        tick();
        idle();
        expect_val("mr.l4", SEL_LEFT, 4);
        tick();
        expect_val("mr.l3", SEL_LEFT, 3);
        tick();
        rstn = 1'b0;
        expect_ctl("mr.rst", 2'b00, 1'b0, 1'b0, 0);
        expect_val("mr.cyc", SEL_CYC, 0);
        expect_val("mr.stall", SEL_STALL, 0);
        expect_val("mr.rdy", SEL_RDY, 0);
        tick();
        rstn = 1'b1;
        expect_val("mr.rel.rdy0", SEL_RDY, 0);
        #1;
        drain();
        expect_val("mr.rel.rdy1", SEL_RDY, 1);
        expect_val("mr.rel.done", SEL_DONE, 0);
        tick();
        expect_val("mr.rel.rdy2", SEL_RDY, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
